// File: rtl/gray_to_binary_seq.sv
// rtl/gray_to_binary_seq.sv - iterative MSB-first Gray-to-binary decoder with valid/ready ports
// Also flags accepted codes that are not a single-bit step from the previous code.
module gray_to_binary_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] G,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             step_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = (WIDTH > 1) ? IW'(WIDTH - 2) : '0;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state;
  logic [WIDTH-1:0] g_reg;
  logic [WIDTH-1:0] prev_g;
  logic [IW-1:0]    idx;
  logic             have_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      B         <= '0;
      step_err  <= 1'b0;
      g_reg     <= '0;
      idx       <= '0;
      have_prev <= 1'b0;
      prev_g    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            g_reg          <= G;
            B[WIDTH-1]     <= G[WIDTH-1];
            idx            <= IDX_TOP;
            step_err       <= have_prev ? ($countones(G ^ prev_g) != 1) : 1'b0;
            prev_g         <= G;
            have_prev      <= 1'b1;
            in_ready       <= 1'b0;
            if (WIDTH == 1) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= CONV;
            end
          end
        end

        CONV: begin
          // Bit idx folds in the already-decoded bit above it; MSB stays as captured.
          B[WIDTH-1] <= g_reg[WIDTH-1];
          for (int i = 0; i < WIDTH - 1; i++) begin
            if (idx == IW'(i)) begin
              B[i] <= B[i+1] ^ g_reg[i];
            end
          end
          if (idx == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// tb/tb_gray_to_binary_seq.sv - directed self-checking bench for gray_to_binary_seq
// Drives a WIDTH=4 and a WIDTH=1 instance; samples on the falling edge.
module tb_gray_to_binary_seq;

  logic clk;
  logic rst;

  logic       iv4, ir4, ov4, or4, e4;
  logic [3:0] g4, b4;
  logic       iv1, ir1, ov1, or1, e1;
  logic [0:0] g1, b1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;

  gray_to_binary_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4), .G(g4),
    .out_valid(ov4), .out_ready(or4), .B(b4), .step_err(e4)
  );

  gray_to_binary_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .G(g1),
    .out_valid(ov1), .out_ready(or1), .B(b1), .step_err(e1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic       s4, s1;
    logic [3:0] p4;
    logic       p1;
    s4 = ov4 && !or4 && !rst;
    s1 = ov1 && !or1 && !rst;
    p4 = b4;
    p1 = b1[0];
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("excl4", {31'd0, ir4 && ov4}, 0);
    chk("excl1", {31'd0, ir1 && ov1}, 0);
    if (s4) chk("hold4", {28'd0, b4}, {28'd0, p4});
    if (s1) chk("hold1", {31'd0, b1[0]}, {31'd0, p1});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic decode(input bit w1, input logic [3:0] g, input logic [3:0] eb,
                        input logic ee, input bit hold, input string tag);
    int n;
    chk({tag, "_rdy"}, {31'd0, w1 ? ir1 : ir4}, 1);
    if (w1) begin iv1 = 1'b1; g1 = g[0]; end
    else    begin iv4 = 1'b1; g4 = g;    end
    tick();
    acc_cyc = cyc;
    iv1 = 1'b0;
    iv4 = 1'b0;
    n = 0;
    while (!(w1 ? ov1 : ov4) && n < 20) begin
      chk({tag, "_busy"}, {31'd0, w1 ? ir1 : ir4}, 0);
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, w1 ? 0 : 3);
    chk({tag, "_B"}, {28'd0, w1 ? {3'd0, b1} : b4}, {28'd0, eb});
    chk({tag, "_err"}, {31'd0, w1 ? e1 : e4}, {31'd0, ee});
    if (w1) or1 = 1'b1; else or4 = 1'b1;
    tick();
    if (!hold) begin or1 = 1'b0; or4 = 1'b0; end
    chk({tag, "_ovlo"}, {31'd0, w1 ? ov1 : ov4}, 0);
    chk({tag, "_rdyhi"}, {31'd0, w1 ? ir1 : ir4}, 1);
  endtask

  initial begin
    rst = 1'b1;
    iv4 = 1'b0; or4 = 1'b0; g4 = 4'b0000;
    iv1 = 1'b0; or1 = 1'b0; g1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdy4", {31'd0, ir4}, 1);
    chk("rst_ov4", {31'd0, ov4}, 0);
    chk("rst_b4", {28'd0, b4}, 0);
    chk("rst_err4", {31'd0, e4}, 0);
    chk("rst_rdy1", {31'd0, ir1}, 1);
    chk("rst_ov1", {31'd0, ov1}, 0);
    chk("rst_b1", {31'd0, b1}, 0);

    decode(1'b0, 4'b1101, 4'b1001, 1'b0, 1'b0, "t1");

    // back-to-back with out_ready held high: accepts 5 cycles apart
    do_reset();
    or4 = 1'b1;
    decode(1'b0, 4'b1101, 4'b1001, 1'b0, 1'b1, "b2b0");
    prev_acc = acc_cyc;
    decode(1'b0, 4'b1010, 4'b1100, 1'b1, 1'b1, "b2b1");
    chk("b2b_gap1", acc_cyc - prev_acc, 5);
    prev_acc = acc_cyc;
    decode(1'b0, 4'b1001, 4'b1110, 1'b1, 1'b1, "b2b2");
    chk("b2b_gap2", acc_cyc - prev_acc, 5);
    or4 = 1'b0;

    do_reset();
    decode(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "s0");
    decode(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, "s1");
    decode(1'b0, 4'b0011, 4'b0010, 1'b0, 1'b0, "s2");
    decode(1'b0, 4'b0010, 4'b0011, 1'b0, 1'b0, "s3");
    decode(1'b0, 4'b0010, 4'b0011, 1'b1, 1'b0, "srep");

    // backpressure: 1000 after 0010 is distance 2
    chk("bp_rdy", {31'd0, ir4}, 1);
    iv4 = 1'b1; g4 = 4'b1000;
    tick();
    iv4 = 1'b0;
    for (int n = 0; n < 20 && !ov4; n++) tick();
    chk("bp_ov", {31'd0, ov4}, 1);
    chk("bp_B", {28'd0, b4}, 4'b1111);
    chk("bp_err", {31'd0, e4}, 1);
    iv4 = 1'b1; g4 = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_stall_ov", {31'd0, ov4}, 1);
      chk("bp_stall_B", {28'd0, b4}, 4'b1111);
      chk("bp_stall_rdy", {31'd0, ir4}, 0);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    chk("bp_done_ov", {31'd0, ov4}, 0);
    chk("bp_done_rdy", {31'd0, ir4}, 1);
    // 1001 is one step from 1000 but two from the ignored 0000
    decode(1'b0, 4'b1001, 4'b1110, 1'b0, 1'b0, "bp_next");

    // reset on the second CONV edge
    iv4 = 1'b1; g4 = 4'b1111;
    tick();
    iv4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ov", {31'd0, ov4}, 0);
    chk("mid_B", {28'd0, b4}, 0);
    chk("mid_rdy", {31'd0, ir4}, 1);
    chk("mid_err", {31'd0, e4}, 0);
    decode(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, "mid_next");

    decode(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "w1_a");
    decode(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "w1_b");
    decode(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, "w1_c");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
